// File: rtl/bus_timer.sv
// bus_timer: programmable 16-bit interval timer on the cpu memory bus.
// Counts prescaled ticks of clk in one-shot or periodic mode and raises
// irq (FLAG & IE) when the count expires.
module bus_timer #(
    parameter int unsigned PRESCALE = 2080
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rnw,
    input  logic       cs,
    output logic       irq
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] reload;
    logic [15:0] count;
    logic [15:0] pre;
    logic [7:0]  snap;
    logic        en;
    logic        auto_mode;
    logic        ie;
    logic        flag;

    logic wr_stb;
    logic rd_stb;
    logic wr_ctrl;
    logic start;
    logic tick;
    logic expire;

    assign wr_stb  = cs & ~rnw;
    assign rd_stb  = cs & rnw;
    assign wr_ctrl = wr_stb && (a == 2'd2);
    // Only a 0->1 transition of EN restarts; rewriting EN=1 just updates AUTO/IE.
    assign start   = wr_ctrl && din[0] && !en;
    assign tick    = en && (pre == PRE_LAST);
    assign expire  = tick && (count == 16'd1);
    assign irq     = flag & ie;

    // Prescaler: free-runs 0..PRESCALE-1 while enabled, held at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (start || !en || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 16'd1;
        end
    end

    // Down-counter: load on start, decrement (wrapping) per tick, reload or stop on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= reload;
        end else if (tick) begin
            if (count == 16'd1) begin
                count <= auto_mode ? reload : 16'd0;
            end else begin
                count <= count - 16'd1;
            end
        end
    end

    // RELOAD bytes are written independently; the running count is unaffected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
        end else if (wr_stb && (a == 2'd0)) begin
            reload[7:0] <= din;
        end else if (wr_stb && (a == 2'd1)) begin
            reload[15:8] <= din;
        end
    end

    // Control bits: a one-shot expiry clears EN after any same-cycle bus write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en        <= 1'b0;
            auto_mode <= 1'b0;
            ie        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en        <= din[0];
                auto_mode <= din[1];
                ie        <= din[2];
            end
            if (expire && !auto_mode) begin
                en <= 1'b0;
            end
        end
    end

    // FLAG: set on expiry, cleared by reg3 write with din[7]; set wins a tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag <= 1'b0;
        end else if (expire) begin
            flag <= 1'b1;
        end else if (wr_stb && (a == 2'd3) && din[7]) begin
            flag <= 1'b0;
        end
    end

    // Snapshot of COUNT[15:8] taken on every reg0 read strobe for a coherent 16-bit read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap <= '0;
        end else if (rd_stb && (a == 2'd0)) begin
            snap <= count[15:8];
        end
    end

    // Read mux: always reflects the selected register, independent of cs.
    always_comb begin
        dout = '0;
        case (a)
            2'd0:    dout = count[7:0];
            2'd1:    dout = snap;
            2'd2:    dout = {flag, 4'b0000, ie, auto_mode, en};
            default: dout = {flag, 7'b0000000};
        endcase
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed, self-checking bench for bus_timer using one
// instance with PRESCALE=4 and one with PRESCALE=1 on a shared bus.
module tb_bus_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] a = 2'd0;
    logic [7:0] din = 8'd0;
    logic       rnw = 1'b1;
    logic       cs4 = 1'b0;
    logic       cs1 = 1'b0;
    logic [7:0] dout4;
    logic [7:0] dout1;
    logic       irq4;
    logic       irq1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       cs;
        logic       rnw;
        logic [1:0] a;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[19];

    bus_timer #(.PRESCALE(4)) u_dut4 (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .din  (din),
        .dout (dout4),
        .rnw  (rnw),
        .cs   (cs4),
        .irq  (irq4)
    );

    bus_timer #(.PRESCALE(1)) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .din  (din),
        .dout (dout1),
        .rnw  (rnw),
        .cs   (cs1),
        .irq  (irq1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got incomplete run required summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h required 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [1:0] aa, input logic [7:0] exp);
        a = aa;
        #1;
        chk(name, dout4, exp);
    endtask

    task automatic chk1(input string name, input logic [1:0] aa, input logic [7:0] exp);
        a = aa;
        #1;
        chk(name, dout1, exp);
    endtask

    task automatic wr(input bit sel1, input logic [1:0] aa, input logic [7:0] d);
        @(negedge clk);
        a = aa;
        din = d;
        rnw = 1'b0;
        if (sel1) cs1 = 1'b1;
        else      cs4 = 1'b1;
        @(posedge clk);
        #1;
        cs4 = 1'b0;
        cs1 = 1'b0;
        rnw = 1'b1;
    endtask

    task automatic wr_nocs(input logic [1:0] aa, input logic [7:0] d);
        @(negedge clk);
        a = aa;
        din = d;
        rnw = 1'b0;
        cs4 = 1'b0;
        @(posedge clk);
        #1;
        rnw = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic c, input logic r, input logic [1:0] aa,
                                input logic [7:0] d, input logic [7:0] ed, input logic ei);
        vec_t v;
        v.cs = c; v.rnw = r; v.a = aa; v.din = d; v.exp_dout = ed; v.exp_irq = ei;
        return v;
    endfunction

    initial begin
        // One-shot run on PRESCALE=4: RELOAD=3, EN|IE; expiry 12 edges after the enabling edge.
        tbl[0] = mk(1'b1, 1'b0, 2'd0, 8'h03, 8'h00, 1'b0);
        tbl[1] = mk(1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0);
        tbl[2] = mk(1'b1, 1'b0, 2'd2, 8'h05, 8'h00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tbl[3 + k] = mk(1'b0, 1'b1, 2'd0, 8'h00, 8'(3 - k / 4), 1'b0);
        end
        tbl[15] = mk(1'b1, 1'b1, 2'd2, 8'h00, 8'h84, 1'b1);
        tbl[16] = mk(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1);
        tbl[17] = mk(1'b1, 1'b0, 2'd3, 8'h80, 8'h80, 1'b1);
        tbl[18] = mk(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b0);

        // Reset mid-count.
        #12;
        reset = 1'b0;
        wr(0, 2'd0, 8'h03);
        wr(0, 2'd2, 8'h05);
        ticks(5);
        chk4("pre_reset_count", 2'd0, 8'h02);
        #3;
        reset = 1'b1;
        #1;
        chk("reset_irq_held", {7'd0, irq4}, 8'h00);
        chk4("reset_reg2_held", 2'd2, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        chk4("reset_reg0", 2'd0, 8'h00);
        chk4("reset_reg1", 2'd1, 8'h00);
        chk4("reset_reg2", 2'd2, 8'h00);
        chk4("reset_reg3", 2'd3, 8'h00);
        chk("reset_irq", {7'd0, irq4}, 8'h00);
        ticks(20);
        chk4("reset_no_expiry", 2'd3, 8'h00);

        // Table-driven one-shot.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            cs4 = tbl[i].cs;
            rnw = tbl[i].rnw;
            a   = tbl[i].a;
            din = tbl[i].din;
            #1;
            chk($sformatf("oneshot_dout[%0d]", i), dout4, tbl[i].exp_dout);
            chk($sformatf("oneshot_irq[%0d]", i), {7'd0, irq4}, {7'd0, tbl[i].exp_irq});
        end
        @(negedge clk);
        cs4 = 1'b0;
        rnw = 1'b1;

        // Periodic: RELOAD=2, EN|AUTO, IE=0.
        do_reset();
        wr(0, 2'd0, 8'h02);
        wr(0, 2'd1, 8'h00);
        wr(0, 2'd2, 8'h03);
        chk4("per_count_e0", 2'd0, 8'h02);
        ticks(4);
        chk4("per_count_e4", 2'd0, 8'h01);
        ticks(3);
        chk4("per_flag_e7", 2'd3, 8'h00);
        ticks(1);
        chk4("per_flag_e8", 2'd3, 8'h80);
        chk4("per_count_e8", 2'd0, 8'h02);
        wr(0, 2'd3, 8'h80);
        chk4("per_clear_e9", 2'd3, 8'h00);
        ticks(3);
        chk4("per_count_e12", 2'd0, 8'h01);
        ticks(3);
        chk4("per_flag_e15", 2'd3, 8'h00);
        ticks(1);
        chk4("per_flag_e16", 2'd3, 8'h80);
        chk("per_irq_masked", {7'd0, irq4}, 8'h00);
        chk4("per_reg2_e16", 2'd2, 8'h83);

        // Clear write landing on the expiry edge: set wins.
        wr(0, 2'd3, 8'h80);
        chk4("sim_clear_e17", 2'd3, 8'h00);
        ticks(6);
        chk4("sim_flag_e23", 2'd3, 8'h00);
        wr(0, 2'd3, 8'h80);
        chk4("sim_flag_e24", 2'd3, 8'h80);
        chk4("sim_count_e24", 2'd0, 8'h02);

        // Rewriting EN=1 while running does not move the expiry.
        do_reset();
        wr(0, 2'd0, 8'h03);
        wr(0, 2'd1, 8'h00);
        wr(0, 2'd2, 8'h01);
        ticks(5);
        wr(0, 2'd2, 8'h01);
        ticks(5);
        chk4("rewr_flag_e11", 2'd3, 8'h00);
        ticks(1);
        chk4("rewr_flag_e12", 2'd3, 8'h80);
        chk4("rewr_reg2_e12", 2'd2, 8'h80);

        // EN 1->0->1 restarts from RELOAD.
        wr(0, 2'd3, 8'h80);
        wr(0, 2'd2, 8'h01);
        ticks(5);
        chk4("rst_count_f5", 2'd0, 8'h02);
        wr(0, 2'd2, 8'h00);
        chk4("rst_reg2_off", 2'd2, 8'h00);
        wr(0, 2'd2, 8'h01);
        chk4("rst_count_f7", 2'd0, 8'h03);
        ticks(11);
        chk4("rst_flag_f18", 2'd3, 8'h00);
        ticks(1);
        chk4("rst_flag_f19", 2'd3, 8'h80);

        // cs=0 writes change nothing.
        wr_nocs(2'd3, 8'h80);
        chk4("nocs_reg3", 2'd3, 8'h80);
        wr_nocs(2'd2, 8'h07);
        chk4("nocs_reg2", 2'd2, 8'h80);
        wr_nocs(2'd0, 8'h09);
        wr(0, 2'd2, 8'h01);
        chk4("nocs_reload", 2'd0, 8'h03);
        wr(0, 2'd2, 8'h00);

        // Snapshot on PRESCALE=1: RELOAD=0x0100.
        do_reset();
        wr(1, 2'd0, 8'h00);
        wr(1, 2'd1, 8'h01);
        wr(1, 2'd2, 8'h01);
        a = 2'd0;
        rnw = 1'b1;
        cs1 = 1'b1;
        #1;
        chk("snap_reg0_100", dout1, 8'h00);
        @(posedge clk);
        #1;
        chk("snap_reg0_ff", dout1, 8'hFF);
        @(posedge clk);
        #1;
        cs1 = 1'b0;
        chk1("snap_reg1_after_ff", 2'd1, 8'h00);
        chk1("snap_live_fe", 2'd0, 8'hFE);
        wr(1, 2'd2, 8'h00);
        wr(1, 2'd2, 8'h01);
        a = 2'd0;
        rnw = 1'b1;
        cs1 = 1'b1;
        @(posedge clk);
        #1;
        cs1 = 1'b0;
        ticks(3);
        chk1("snap_reg1_held", 2'd1, 8'h01);
        chk1("snap_live_fc", 2'd0, 8'hFC);

        // RELOAD=0 with PRESCALE=1: expiry after 65536 edges.
        do_reset();
        wr(1, 2'd0, 8'h00);
        wr(1, 2'd1, 8'h00);
        wr(1, 2'd2, 8'h05);
        ticks(65535);
        chk1("wrap_flag_65535", 2'd3, 8'h00);
        chk("wrap_irq_65535", {7'd0, irq1}, 8'h00);
        ticks(1);
        chk1("wrap_flag_65536", 2'd3, 8'h80);
        chk("wrap_irq_65536", {7'd0, irq1}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
